video_scandbl: RTL

VIDEO_SCANDBL -- requirements
Module: video_scandbl

---
 rtl/video_scandbl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/video_scandbl.sv
// Scan doubler: buffers one TV line and replays it twice at VGA rate.
// Two ping-pong line RAMs; read path has a fixed 2-clock latency.
module video_scandbl #(
  parameter int LINE_PIX = 448,
  parameter int HALF     = 448,
  parameter int HS_BEG   = 8,
  parameter int HS_LEN   = 52
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] tvcolor,
  input  logic       pix_stb,
  input  logic       line_start,
  output logic [5:0] vgacolor,
  output logic       vga_hsync,
  output logic       vga_lstart
);

  localparam int PW = $clog2(LINE_PIX + 1);
  localparam int AW = (LINE_PIX > 1) ? $clog2(LINE_PIX) : 1;
  localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CW = (PW > HW) ? PW : HW;

  localparam logic [PW-1:0] PTR_FULL  = PW'(LINE_PIX);
  localparam logic [HW-1:0] HCNT_LAST = HW'(HALF - 1);
  localparam logic [CW-1:0] HS_FIRST  = CW'(HS_BEG);
  localparam logic [CW-1:0] HS_LAST   = CW'(HS_BEG + HS_LEN - 1);

  // line buffers, never reset
  logic [5:0] mem0 [LINE_PIX];
  logic [5:0] mem1 [LINE_PIX];

  // write side
  logic          wr_bank;
  logic [PW-1:0] wr_ptr;
  logic          primed;
  logic          ptr_room;
  logic          wr_en;
  logic          wr_sel;
  logic [AW-1:0] wr_addr;

  // read side
  logic [PW-1:0] rd_len;
  logic [HW-1:0] vga_hcnt;
  logic          rep;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] hcnt_ext;
  logic [CW-1:0] len_ext;
  logic          rd_hit;
  logic          hs_hit;
  logic          ls_hit;

  // stage-1 pipeline
  logic [5:0]    pix_q;
  logic          vis_q;
  logic          hs_q;
  logic          ls_q;

  // Write port steering: a strobe coincident with line_start
  // becomes pixel 0 of the freshly selected bank.
  always_comb begin
    ptr_room = (wr_ptr < PTR_FULL);
    wr_sel   = wr_bank;
    wr_addr  = AW'(wr_ptr);
    wr_en    = 1'b0;
    if (line_start) begin
      wr_sel  = ~wr_bank;
      wr_addr = '0;
      wr_en   = pix_stb;
    end else begin
      wr_en   = pix_stb && ptr_room;
    end
    if (rst) begin
      wr_en = 1'b0;
    end
  end

  // Read address decode and sync window compares.
  always_comb begin
    rd_addr  = AW'(vga_hcnt);
    hcnt_ext = CW'(vga_hcnt);
    len_ext  = CW'(rd_len);
    rd_hit   = (hcnt_ext < len_ext);
    hs_hit   = (hcnt_ext >= HS_FIRST) &&
               (hcnt_ext <= HS_LAST);
    ls_hit   = (vga_hcnt == '0);
  end

  // Bank 0 RAM write.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_sel) begin
      mem0[wr_addr] <= tvcolor;
    end
  end

  // Bank 1 RAM write.
  always_ff @(posedge clk) begin
    if (wr_en && wr_sel) begin
      mem1[wr_addr] <= tvcolor;
    end
  end

  // Line bookkeeping: bank swap, write pointer, VGA half-line counter.
  // The first line_start after reset only arms the doubler, so a
  // partial line captured around reset is never replayed.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank  <= 1'b0;
      wr_ptr   <= '0;
      rd_len   <= '0;
      primed   <= 1'b0;
      vga_hcnt <= '0;
      rep      <= 1'b0;
    end else if (line_start) begin
      rd_len   <= primed ? wr_ptr : '0;
      primed   <= 1'b1;
      wr_bank  <= ~wr_bank;
      wr_ptr   <= pix_stb ? PW'(1) : '0;
      vga_hcnt <= '0;
      rep      <= 1'b0;
    end else begin
      if (pix_stb && ptr_room) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (vga_hcnt == HCNT_LAST) begin
        vga_hcnt <= '0;
        rep      <= ~rep;
      end else begin
        vga_hcnt <= vga_hcnt + HW'(1);
      end
    end
  end

  // Stage 1: RAM read from the bank not being written, plus
  // the sync/visibility flags aligned with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q <= '0;
      vis_q <= 1'b0;
      hs_q  <= 1'b0;
      ls_q  <= 1'b0;
    end else begin
      pix_q <= wr_bank ? mem0[rd_addr] : mem1[rd_addr];
      vis_q <= rd_hit;
      hs_q  <= hs_hit;
      ls_q  <= ls_hit;
    end
  end

  // Stage 2: output register, blanking past the stored length.
  always_ff @(posedge clk) begin
    if (rst) begin
      vgacolor   <= '0;
      vga_hsync  <= 1'b0;
      vga_lstart <= 1'b0;
    end else begin
      vgacolor   <= vis_q ? pix_q : 6'h00;
      vga_hsync  <= hs_q;
      vga_lstart <= ls_q;
    end
  end

endmodule
